// File: rtl/mem_stream_tx_pkg.sv
// Shared register map and bit positions for the mem_stream_tx bus-to-stream bridge.
package mem_stream_tx_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_STATUS = 2'd1,
        ADDR_CTRL   = 2'd2,
        ADDR_FLAGS  = 2'd3
    } reg_addr_e;

    localparam int CTRL_CLR     = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_LWM_LSB = 8;
    localparam int STATUS_EMPTY = 16;
    localparam int STATUS_FULL  = 17;
    localparam int FLAGS_OVF    = 0;

endpackage

// File: rtl/mem_sfifo.sv
// Synchronous FIFO with registered pointers/count and a combinational head word.
module mem_sfifo #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          mclk,
    input  logic          mrst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // NOTE: the data array has no reset; contents are only observable through valid pointers.
    always_ff @(posedge mclk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign head  = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/mem_stream_tx.sv
// Memory-bus slave pushing DATA writes into a FIFO drained as a valid/ready stream.
// Optional irq logic and CTRL IRQ_EN/LWM fields are built when MEM_STREAM_TX_IRQ_EN is defined.
module mem_stream_tx
    import mem_stream_tx_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 16,
    parameter int DEPTH = 16
) (
    input  logic          mclk,
    input  logic          mrst,
    input  logic          mcsn,
    input  logic          mwr,
    input  logic [AW-1:0] maddr,
    input  logic [DW-1:0] mwdata,
    output logic [DW-1:0] mrdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    reg_addr_e     addr;
    logic          acc_wr;
    logic          acc_rd;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          clr;
    logic          ovf;
    logic          ovf_next;
    logic [DW-1:0] head;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          empty;
    logic          full;
    logic [DW-1:0] ctrl_rd_val;
    logic [DW-1:0] rd_val;

    assign addr     = reg_addr_e'(maddr[1:0]);
    assign acc_wr   = !mcsn && mwr;
    assign acc_rd   = !mcsn && !mwr;
    assign push_req = acc_wr && (addr == ADDR_DATA);
    assign pop      = !empty && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok  = push_req && (!full || pop);
    assign clr      = acc_wr && (addr == ADDR_CTRL) && mwdata[CTRL_CLR];
    assign ovf_next = (push_req && !push_ok) ||
                      (ovf && !(acc_wr && (addr == ADDR_FLAGS) && mwdata[FLAGS_OVF]));

    mem_sfifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .mclk  (mclk),
        .mrst  (mrst),
        .push  (push_ok),
        .pop   (pop && !clr),
        .clr   (clr),
        .wdata (mwdata),
        .head  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        count_next = count;
        if (clr)                  count_next = '0;
        else if (push_ok && !pop) count_next = count + CW'(1);
        else if (pop && !push_ok) count_next = count - CW'(1);
    end

`ifdef MEM_STREAM_TX_IRQ_EN
    logic          irq_en;
    logic          irq_en_next;
    logic [CW-1:0] lwm;
    logic [CW-1:0] lwm_next;
    logic          ctrl_wr;

    assign ctrl_wr     = acc_wr && (addr == ADDR_CTRL);
    assign irq_en_next = ctrl_wr ? mwdata[CTRL_IRQ_EN] : irq_en;
    assign lwm_next    = ctrl_wr ? mwdata[CTRL_LWM_LSB +: CW] : lwm;

    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            irq_en <= 1'b0;
            lwm    <= '0;
            irq    <= 1'b0;
        end else begin
            irq_en <= irq_en_next;
            lwm    <= lwm_next;
            irq    <= irq_en_next && ((count_next <= lwm_next) || ovf_next);
        end
    end

    always_comb begin
        ctrl_rd_val                        = '0;
        ctrl_rd_val[CTRL_IRQ_EN]           = irq_en;
        ctrl_rd_val[CTRL_LWM_LSB +: CW]    = lwm;
    end
`else
    logic unused_count_next;

    assign unused_count_next = ^count_next;
    assign irq               = 1'b0;
    assign ctrl_rd_val       = '0;
`endif

    // NOTE: defaulting rd_val before the case keeps this block free of inferred latches.
    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_STATUS: begin
                rd_val[CW-1:0]      = count;
                rd_val[STATUS_EMPTY] = empty;
                rd_val[STATUS_FULL]  = full;
            end
            ADDR_CTRL:  rd_val = ctrl_rd_val;
            ADDR_FLAGS: rd_val[FLAGS_OVF] = ovf;
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            mrdata <= '0;
            ovf    <= 1'b0;
        end else begin
            if (acc_rd) mrdata <= rd_val;
            ovf <= ovf_next;
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : head;

    // Upper address bits and unmapped write-data bits are intentionally ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{maddr[AW-1:2], mwdata};

endmodule

// File: tb/tb_mem_stream_tx.sv
// Directed self-checking bench for mem_stream_tx (default or MEM_STREAM_TX_IRQ_EN build).
module tb_mem_stream_tx;
    import mem_stream_tx_pkg::*;

    logic        mclk = 1'b0;
    logic        mrst = 1'b1;
    logic        mcsn = 1'b1;
    logic        mwr = 1'b0;
    logic [15:0] maddr = '0;
    logic [31:0] mwdata = '0;
    logic [31:0] mrdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    mem_stream_tx #(.DW(32), .AW(16), .DEPTH(16)) dut (
        .mclk(mclk), .mrst(mrst), .mcsn(mcsn), .mwr(mwr), .maddr(maddr),
        .mwdata(mwdata), .mrdata(mrdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .irq(irq)
    );

    always #5 mclk = ~mclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    // All bus tasks start and end on a falling edge; one access per rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        mcsn = 1'b0; mwr = 1'b1; maddr = {14'd0, a}; mwdata = d;
        @(negedge mclk);
        mcsn = 1'b1; mwr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        mcsn = 1'b0; mwr = 1'b0; maddr = {14'd0, a};
        @(negedge mclk);
        mcsn = 1'b1;
        d = mrdata;
    endtask

    task automatic push_word(input logic [31:0] d);
        bus_write(ADDR_DATA, d);
        if (exp_q.size() < 16) exp_q.push_back(d);
    endtask

    task automatic drain(input string nm);
        int guard = 0;
        logic [31:0] w;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 64) begin
            if (out_valid) begin
                w = exp_q.pop_front();
                checks++;
                if (out_data !== w) begin
                    failures++;
                    $display("FAIL %s word: got %h expected %h", nm, out_data, w);
                end
            end
            guard++;
            @(negedge mclk);
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s end: out_valid=%b leftover=%0d expected 0/0", nm, out_valid, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] r;
        mrst = 1'b1;
        repeat (2) @(negedge mclk);
        mrst = 1'b0;
        checks++;
        if ({out_valid, irq, out_data, mrdata} !== 66'd0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b irq=%b data=%h rdata=%h expected all 0",
                     out_valid, irq, out_data, mrdata);
        end
        bus_read(ADDR_STATUS, r);
        checks++;
        if (r !== 32'h0001_0000) begin
            failures++; $display("FAIL reset_status: got %h expected 00010000", r);
        end
        bus_read(ADDR_CTRL, r);
        checks++;
        if (r !== 32'h0) begin
            failures++; $display("FAIL reset_ctrl: got %h expected 00000000", r);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] r;
        for (int i = 1; i <= 16; i++) push_word(32'hA5A5_0000 + 32'(i));
        bus_read(ADDR_STATUS, r);
        checks++;
        if (r !== 32'h0002_0010) begin
            failures++; $display("FAIL full_status: got %h expected 00020010", r);
        end
        checks++;
        if (out_data !== 32'hA5A5_0001) begin
            failures++; $display("FAIL full_head: got %h expected a5a50001", out_data);
        end
        push_word(32'hDEAD_BEEF);
        bus_read(ADDR_FLAGS, r);
        checks++;
        if (r !== 32'h1) begin
            failures++; $display("FAIL ovf_set: got %h expected 00000001", r);
        end
        drain("overflow_drain");
        bus_write(ADDR_FLAGS, 32'h1);
        bus_read(ADDR_FLAGS, r);
        checks++;
        if (r !== 32'h0) begin
            failures++; $display("FAIL ovf_w1c: got %h expected 00000000", r);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] r;
        for (int i = 0; i < 16; i++) push_word(32'h0000_0100 + 32'(i));
        checks++;
        if (out_data !== 32'h0000_0100) begin
            failures++; $display("FAIL pushpop_head: got %h expected 00000100", out_data);
        end
        out_ready = 1'b1;
        bus_write(ADDR_DATA, 32'h1234_5678);
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(32'h1234_5678);
        bus_read(ADDR_STATUS, r);
        checks++;
        if (r !== 32'h0002_0010) begin
            failures++; $display("FAIL pushpop_status: got %h expected 00020010", r);
        end
        bus_read(ADDR_FLAGS, r);
        checks++;
        if (r !== 32'h0) begin
            failures++; $display("FAIL pushpop_ovf: got %h expected 00000000", r);
        end
        drain("pushpop_drain");
    endtask

    task automatic test_irq();
        logic [31:0] r;
        for (int i = 0; i < 6; i++) push_word(32'h0000_0600 + 32'(i));
        bus_write(ADDR_CTRL, 32'h0000_0402);
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_above_lwm: got %b expected 0", irq);
        end
        bus_read(ADDR_CTRL, r);
`ifdef MEM_STREAM_TX_IRQ_EN
        checks++;
        if (r !== 32'h0000_0402) begin
            failures++; $display("FAIL ctrl_readback: got %h expected 00000402", r);
        end
        out_ready = 1'b1; @(negedge mclk); out_ready = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_count5: got %b expected 0", irq);
        end
        out_ready = 1'b1; @(negedge mclk); out_ready = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL irq_count4: got %b expected 1", irq);
        end
        drain("irq_drain");
        bus_write(ADDR_CTRL, 32'h0);
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_disable: got %b expected 0", irq);
        end
`else
        checks++;
        if (r !== 32'h0) begin
            failures++; $display("FAIL ctrl_readback: got %h expected 00000000", r);
        end
        drain("irq_drain");
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_tied: got %b expected 0", irq);
        end
`endif
    endtask

    task automatic test_clr();
        logic [31:0] r;
        for (int i = 0; i < 5; i++) push_word(32'h0000_0500 + 32'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_data !== 32'h0000_0500 + 32'(i)) begin
                failures++; $display("FAIL clr_prepop: got %h expected %h", out_data, 32'h500 + 32'(i));
            end
            @(negedge mclk);
        end
        bus_write(ADDR_CTRL, 32'h1);
        out_ready = 1'b0;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            failures++; $display("FAIL clr_outputs: valid=%b data=%h expected 0/0", out_valid, out_data);
        end
        bus_read(ADDR_STATUS, r);
        checks++;
        if (r !== 32'h0001_0000) begin
            failures++; $display("FAIL clr_status: got %h expected 00010000", r);
        end
        bus_read(ADDR_CTRL, r);
        checks++;
        if (r !== 32'h0) begin
            failures++; $display("FAIL clr_readzero: got %h expected 00000000", r);
        end
        push_word(32'h0000_5A5A);
        drain("clr_after");
    endtask

    task automatic test_ovf_w1c();
        logic [31:0] r;
        for (int i = 0; i < 16; i++) push_word(32'h0000_0700 + 32'(i));
        bus_write(ADDR_DATA, 32'hBAD0_0001);
        bus_write(ADDR_FLAGS, 32'h1);
        bus_read(ADDR_FLAGS, r);
        checks++;
        if (r !== 32'h0) begin
            failures++; $display("FAIL w1c_after_set: got %h expected 00000000", r);
        end
        bus_write(ADDR_FLAGS, 32'h1);
        bus_write(ADDR_DATA, 32'hBAD0_0002);
        bus_read(ADDR_FLAGS, r);
        checks++;
        if (r !== 32'h1) begin
            failures++; $display("FAIL set_after_w1c: got %h expected 00000001", r);
        end
        bus_write(ADDR_FLAGS, 32'h0);
        bus_read(ADDR_FLAGS, r);
        checks++;
        if (r !== 32'h1) begin
            failures++; $display("FAIL w0_keeps: got %h expected 00000001", r);
        end
        drain("w1c_drain");
        bus_write(ADDR_FLAGS, 32'h1);
    endtask

    initial begin
        @(negedge mclk);
        test_reset();
        test_fill_overflow();
        test_full_push_pop();
        test_irq();
        test_clr();
        test_ovf_w1c();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
